stopwatch_ctrl: RTL

Run/pause/lap/clear sequencer for the stopwatch counting datapath. Takes one-cycle button pulses (already debounced and one-pulsed upstream) and runs the mode FSM. Divides clk into a count tick and maintains the live BCD MM:SS time. Drives the display value, which is either live or a frozen lap snapshot, plus the count and LED enables.

---
 rtl/stopwatch_ctrl.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/stopwatch_ctrl.sv
// Stopwatch mode sequencer: IDLE/RUN/PAUSE/LAP FSM, tick prescaler, BCD MM:SS
// live time, lap snapshot and the registered display mux.
module stopwatch_ctrl #(
  parameter int unsigned TICK_DIV = 40000000,
  parameter int unsigned DIV_W    = 26
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start_pulse,
  input  logic       lap_pulse,
  input  logic       clr_pulse,
  output logic       count_enable,
  output logic       led_en,
  output logic [1:0] state,
  output logic       tick,
  output logic       wrapped,
  output logic [3:0] disp_min_tens,
  output logic [3:0] disp_min_ones,
  output logic [3:0] disp_sec_tens,
  output logic [3:0] disp_sec_ones
);

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_RUN   = 2'b01;
  localparam logic [1:0] S_PAUSE = 2'b10;
  localparam logic [1:0] S_LAP   = 2'b11;

  localparam logic [DIV_W-1:0] C_DIV_LAST = DIV_W'(TICK_DIV - 1);

  logic [1:0]       r_state;
  logic [1:0]       w_state_next;
  logic             w_clear;
  logic             w_lap_take;
  logic             w_counting;

  logic [DIV_W-1:0] r_presc;
  logic             w_presc_last;
  logic             w_step;

  logic [4:0]       w_carry;
  logic [15:0]      w_live;
  logic [15:0]      w_disp;

  logic             r_tick;
  logic             r_wrapped;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state: only the highest-priority pulse present is considered; if the
  // current state ignores it, the lower-priority pulses are dropped as well.
  always_comb begin
    w_state_next = r_state;
    w_clear      = 1'b0;
    w_lap_take   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!clr_pulse && start_pulse) begin
          w_state_next = S_RUN;
        end
      end
      S_RUN: begin
        if (!clr_pulse) begin
          if (start_pulse) begin
            w_state_next = S_PAUSE;
          end else if (lap_pulse) begin
            w_state_next = S_LAP;
            w_lap_take   = 1'b1;
          end
        end
      end
      S_LAP: begin
        if (!clr_pulse) begin
          if (start_pulse) begin
            w_state_next = S_PAUSE;
          end else if (lap_pulse) begin
            w_state_next = S_RUN;
          end
        end
      end
      S_PAUSE: begin
        if (clr_pulse) begin
          w_state_next = S_IDLE;
          w_clear      = 1'b1;
        end else if (start_pulse) begin
          w_state_next = S_RUN;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Moore outputs
  always_comb begin
    w_counting = (r_state == S_RUN) || (r_state == S_LAP);
  end

  assign count_enable = w_counting;
  assign led_en       = w_counting;
  assign state        = r_state;

  assign w_presc_last = (r_presc == C_DIV_LAST);
  assign w_step       = w_counting && w_presc_last;

  // Prescaler holds in PAUSE so a resume continues the residual period.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_presc <= '0;
    end else if (w_clear) begin
      r_presc <= '0;
    end else if (w_counting) begin
      r_presc <= w_presc_last ? '0 : r_presc + 1'b1;
    end
  end

  // Digit 0 = sec ones, 1 = sec tens, 2 = min ones, 3 = min tens.
  assign w_carry[0] = w_step;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_digit
      localparam logic [3:0] C_MAX = (gi % 2 == 0) ? 4'd9 : 4'd5;

      logic [3:0] r_live;
      logic [3:0] r_snap;
      logic [3:0] r_disp;
      logic       w_at_max;

      assign w_at_max       = (r_live == C_MAX);
      assign w_carry[gi+1]  = w_carry[gi] & w_at_max;
      assign w_live[gi*4 +: 4] = r_live;
      assign w_disp[gi*4 +: 4] = r_disp;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_live <= 4'd0;
        end else if (w_clear) begin
          r_live <= 4'd0;
        end else if (w_carry[gi]) begin
          r_live <= w_at_max ? 4'd0 : r_live + 4'd1;
        end
      end

      // Snapshot takes the pre-edge live value even if a tick lands on the same edge.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_snap <= 4'd0;
        end else if (w_lap_take) begin
          r_snap <= r_live;
        end
      end

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_disp <= 4'd0;
        end else begin
          r_disp <= (r_state == S_LAP) ? r_snap : r_live;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tick    <= 1'b0;
      r_wrapped <= 1'b0;
    end else begin
      r_tick    <= w_step;
      r_wrapped <= w_carry[4];
    end
  end

  // Masked so a pulse never shows once the FSM has left RUN/LAP on the same edge.
  assign tick    = r_tick & w_counting;
  assign wrapped = r_wrapped & w_counting;

  assign disp_sec_ones = w_disp[3:0];
  assign disp_sec_tens = w_disp[7:4];
  assign disp_min_ones = w_disp[11:8];
  assign disp_min_tens = w_disp[15:12];

endmodule
